// File: rtl/fetch_stage.sv
// Instruction fetch front end: credit-limited requests to imem, in-order response
// tracking with redirect discard, a 2-entry skid FIFO and a registered decode port.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] target_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr2,
  output logic [31:0] pc2,
  output logic        valid2
);
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fentry_t;

  logic [31:0]      pc_f_q, pc_f_d;
  logic [1:0]       os_q, os_d, disc_q, disc_d, fcnt_q, fcnt_d;
  logic [1:0][31:0] aq_q, aq_d;
  fentry_t [1:0]    fifo_q, fifo_d;
  logic [31:0]      instr2_q, instr2_d, pc2_q, pc2_d;
  logic             valid2_q, valid2_d;
  logic             hs, rv, rv_keep, rv_drop, pop, push, aq_wi, fifo_wi;
  fentry_t          rsp;
  logic             unused_tgt;

  assign unused_tgt = ^target_pc[1:0];

  // Credits count every slot a response could land in, discarded ones included,
  // so the FIFO can never be overrun.
  assign imem_req  = nrst & ~redirect & (({1'b0, os_q} + {1'b0, fcnt_q}) < 3'd2);
  assign imem_addr = pc_f_q;
  assign hs        = imem_req & imem_gnt;
  assign rv        = imem_rvalid & (os_q != 2'd0);
  assign rv_drop   = rv & (disc_q != 2'd0);
  assign rv_keep   = rv & (disc_q == 2'd0);
  assign rsp       = '{pc: aq_q[0], instr: imem_rdata};
  assign pop       = ~redirect & ~stall & (fcnt_q != 2'd0);
  assign push      = ~redirect & rv_keep & (stall | (fcnt_q != 2'd0));
  // Write slots after the same-cycle pop has shifted the queue.
  assign aq_wi     = os_q[0] & ~rv;
  assign fifo_wi   = fcnt_q[0] & ~pop;

  always_comb begin
    pc_f_d   = pc_f_q;
    os_d     = os_q + {1'b0, hs} - {1'b0, rv};
    disc_d   = disc_q;
    fcnt_d   = fcnt_q;
    aq_d     = aq_q;
    fifo_d   = fifo_q;
    instr2_d = instr2_q;
    pc2_d    = pc2_q;
    valid2_d = valid2_q;

    if (rv) aq_d[0] = aq_q[1];
    if (hs) aq_d[aq_wi] = pc_f_q;

    if (redirect) begin
      pc_f_d   = {target_pc[31:2], 2'b00};
      disc_d   = os_d;
      fcnt_d   = 2'd0;
      instr2_d = NOP_INSTR;
      valid2_d = 1'b0;
    end else begin
      if (hs) pc_f_d = pc_f_q + 32'd4;
      disc_d = disc_q - {1'b0, rv_drop};
      fcnt_d = fcnt_q + {1'b0, push} - {1'b0, pop};
      if (pop)  fifo_d[0]       = fifo_q[1];
      if (push) fifo_d[fifo_wi] = rsp;
      if (!stall) begin
        if (pop) begin
          pc2_d    = fifo_q[0].pc;
          instr2_d = fifo_q[0].instr;
          valid2_d = 1'b1;
        end else if (rv_keep) begin
          pc2_d    = rsp.pc;
          instr2_d = rsp.instr;
          valid2_d = 1'b1;
        end else begin
          instr2_d = NOP_INSTR;
          valid2_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_f_q   <= RESET_PC;
      os_q     <= 2'd0;
      disc_q   <= 2'd0;
      fcnt_q   <= 2'd0;
      aq_q     <= '0;
      fifo_q   <= '0;
      instr2_q <= NOP_INSTR;
      pc2_q    <= 32'd0;
      valid2_q <= 1'b0;
    end else begin
      pc_f_q   <= pc_f_d;
      os_q     <= os_d;
      disc_q   <= disc_d;
      fcnt_q   <= fcnt_d;
      aq_q     <= aq_d;
      fifo_q   <= fifo_d;
      instr2_q <= instr2_d;
      pc2_q    <= pc2_d;
      valid2_q <= valid2_d;
    end
  end

  assign instr2 = instr2_q;
  assign pc2    = pc2_q;
  assign valid2 = valid2_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized memory/stall/redirect traffic, a program-order
// reference model and a scoreboard monitor decoupled from stimulus.
`timescale 1ns/1ps
module tb_fetch_stage;
  localparam logic [31:0] RPC_A = 32'hFFFF_FFF8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0, nrst = 1'b0;
  always #5 clk = ~clk;

  logic        stall, redirect, imem_req, imem_gnt, imem_rvalid, valid2;
  logic [31:0] target_pc, imem_addr, imem_rdata, instr2, pc2;
  logic        b_req, b_rv, b_valid2;
  logic [31:0] b_addr, b_rd, b_instr2, b_pc2;

  fetch_stage #(.RESET_PC(RPC_A)) dut (
    .clk(clk), .nrst(nrst), .stall(stall), .redirect(redirect), .target_pc(target_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr2(instr2), .pc2(pc2), .valid2(valid2));

  // Default-parameter instance on a zero-wait memory that returns the address as data.
  fetch_stage dut_b (
    .clk(clk), .nrst(nrst), .stall(1'b0), .redirect(1'b0), .target_pc(32'h0),
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(1'b1),
    .imem_rvalid(b_rv), .imem_rdata(b_rd),
    .instr2(b_instr2), .pc2(b_pc2), .valid2(b_valid2));

  int checks = 0, errors = 0, ndeliv = 0;
  int gnt_pct = 100, rv_pct = 100;
  bit rv_hold = 1'b0, mem_flush = 1'b0, rst_pulse = 1'b0;
  logic [31:0] mq[$];
  logic [31:0] tgt_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic rd, input logic [31:0] tg);
    @(posedge clk); #1;
    stall = st; redirect = rd; target_pc = tg;
    if (rd) tgt_q.push_back(tg);
  endtask

  task automatic wait_valid(input string nm, input logic [31:0] exp_pc);
    for (int i = 0; i < 40 && !valid2; i++) @(negedge clk);
    chk({nm, "_valid"}, 32'(valid2), 32'd1);
    chk({nm, "_pc"}, pc2, exp_pc);
  endtask

  // Memory for the main DUT: in-order responses, at least one cycle after grant.
  initial begin : mem_a
    logic s_hs, s_rv;
    logic [31:0] s_addr;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk);
      s_hs = imem_req & imem_gnt; s_rv = imem_rvalid; s_addr = imem_addr;
      @(posedge clk); #1;
      if (mem_flush || !nrst) begin
        mq.delete(); mem_flush = 1'b0;
      end else if (s_rv && mq.size() > 0) void'(mq.pop_front());
      if (s_hs && nrst) mq.push_back(s_addr);
      imem_gnt = ($urandom_range(0, 99) < gnt_pct);
      if (mq.size() > 0 && !rv_hold && $urandom_range(0, 99) < rv_pct) begin
        imem_rvalid = 1'b1; imem_rdata = mem_word(mq[0]);
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
    end
  end

  initial begin : mem_b
    logic s;
    logic [31:0] a;
    b_rv = 1'b0; b_rd = '0;
    forever begin
      @(negedge clk); s = b_req; a = b_addr;
      @(posedge clk); #1; b_rv = s & nrst; b_rd = a;
    end
  end

  // Scoreboard monitor: expected stream is sequential words from the last fetch target.
  initial begin : monitor
    bit p_ok, p_red, p_stall, p_hs, live;
    logic [31:0] exp_pc, fa, l_instr, l_pc, t;
    logic l_vld;
    int idle;
    p_ok = 0; p_red = 0; p_stall = 0; p_hs = 0; idle = 0;
    exp_pc = RPC_A; fa = RPC_A; l_instr = NOP; l_pc = '0; l_vld = 1'b0; t = '0;
    forever begin
      @(negedge clk);
      live = 1'b0;
      if (!nrst || rst_pulse) begin
        rst_pulse = 1'b0; exp_pc = RPC_A; fa = RPC_A; tgt_q.delete(); idle = 0; p_ok = 1;
      end else if (p_ok) begin
        live = 1'b1;
        if (p_red) begin
          if (tgt_q.size() == 0) chk("tgt_q_underflow", 32'd0, 32'd1);
          else t = tgt_q.pop_front();
          exp_pc = {t[31:2], 2'b00}; fa = exp_pc; idle = 0;
          chk("redir_valid2", 32'(valid2), 32'd0);
          chk("redir_instr2", instr2, NOP);
        end else begin
          if (p_hs) fa = fa + 32'd4;
          if (p_stall) begin
            chk("hold_valid2", 32'(valid2), 32'(l_vld));
            chk("hold_pc2", pc2, l_pc);
            chk("hold_instr2", instr2, l_instr);
          end else if (valid2) begin
            chk("stream_pc2", pc2, exp_pc);
            chk("stream_instr2", instr2, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4; ndeliv++; idle = 0;
          end else begin
            chk("bubble_instr2", instr2, NOP);
            chk("bubble_pc2", pc2, l_pc);
            idle++;
            if (idle == 100) chk("progress_watchdog", 32'(idle), 32'd0);
          end
        end
      end
      if (live) begin
        if (imem_req) chk("imem_addr", imem_addr, fa);
        if (redirect) chk("req_during_redirect", 32'(imem_req), 32'd0);
        if (mq.size() >= 2) chk("credit_req", 32'(imem_req), 32'd0);
      end
      l_instr = instr2; l_pc = pc2; l_vld = valid2;
      p_red = redirect; p_stall = stall; p_hs = imem_req & imem_gnt;
    end
  end

  initial begin : stim
    logic [31:0] tg;
    stall = 1'b0; redirect = 1'b0; target_pc = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_valid2", 32'(valid2), 32'd0);
    chk("rst_instr2", instr2, NOP);
    chk("rst_pc2", pc2, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RPC_A);
    chk("rst_b_instr2", b_instr2, NOP);
    chk("rst_b_addr", b_addr, 32'd0);
    #1 nrst = 1'b1;

    // Latency and throughput from reset, including the address wrap on dut.
    @(posedge clk);
    @(negedge clk);
    chk("lat_e1_valid2", 32'(valid2), 32'd0);
    chk("lat_e1_b_valid2", 32'(b_valid2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("seq_valid2", 32'(valid2), 32'd1);
      chk("seq_pc2", pc2, RPC_A + 32'(4 * i));
      chk("seq_b_valid2", 32'(b_valid2), 32'd1);
      chk("seq_b_pc2", b_pc2, 32'(4 * i));
      chk("seq_b_instr2", b_instr2, 32'(4 * i));
    end

    // Three stalled edges: requests stop once two responses are buffered.
    drive(1, 0, 0);
    @(negedge clk);
    @(negedge clk); chk("stall_req_drop1", 32'(imem_req), 32'd0);
    @(negedge clk); chk("stall_req_drop2", 32'(imem_req), 32'd0);
    drive(0, 0, 0);
    repeat (6) drive(0, 0, 0);

    // Redirect with two requests outstanding.
    rv_hold = 1'b1;
    repeat (3) drive(0, 0, 0);
    @(negedge clk); chk("two_outstanding", 32'(mq.size()), 32'd2);
    drive(0, 1, 32'h0000_0103);
    drive(0, 0, 0);
    rv_hold = 1'b0;
    @(negedge clk); chk("redir_next_addr", imem_addr, 32'h0000_0100);
    wait_valid("redir_first", 32'h0000_0100);

    // Redirect while stalled with a full FIFO.
    repeat (4) drive(1, 0, 0);
    drive(1, 1, 32'h0000_0400);
    drive(1, 0, 0);
    @(negedge clk);
    chk("redir_stall_valid2", 32'(valid2), 32'd0);
    chk("redir_stall_instr2", instr2, NOP);
    drive(0, 0, 0);
    wait_valid("redir_stall_first", 32'h0000_0400);

    // Back-to-back redirects: only the last target survives.
    drive(0, 1, 32'h0000_0800);
    drive(0, 1, 32'h0000_0C02);
    drive(0, 0, 0);
    wait_valid("b2b_first", 32'h0000_0C00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        gnt_pct = int'($urandom_range(30, 100));
        rv_pct  = int'($urandom_range(30, 100));
      end
      tg = $urandom;
      if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, tg);
    end

    // Asynchronous reset pulse with requests in flight, then a stale response.
    gnt_pct = 100; rv_pct = 100;
    drive(0, 0, 0);
    repeat (6) drive(0, 0, 0);
    rv_hold = 1'b1;
    repeat (3) drive(0, 0, 0);
    @(posedge clk); #2;
    nrst = 1'b0; rst_pulse = 1'b1; mem_flush = 1'b1; rv_hold = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("arst_valid2", 32'(valid2), 32'd0);
    chk("arst_instr2", instr2, NOP);
    chk("arst_pc2", pc2, 32'd0);
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, RPC_A);
    #1 nrst = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("arst_e1_valid2", 32'(valid2), 32'd0);
    @(negedge clk);
    chk("arst_e2_valid2", 32'(valid2), 32'd1);
    chk("arst_e2_pc2", pc2, RPC_A);
    repeat (20) drive(0, 0, 0);

    @(negedge clk);
    chk("deliveries", 32'(ndeliv >= 500), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : timeout
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, nrst; all state SHALL clear immediately on nrst low, independent of clk.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble instruction presented to decode.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 nrst  in  1  asynchronous active-low reset.
REQ-006 stall  in  1  decode/backend cannot accept; hold instr2/pc2/valid2.
REQ-007 redirect  in  1  taken branch/jump from execute; refetch from target_pc.
REQ-008 target_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  32  request address, word aligned.
REQ-011 imem_gnt  in  1  request accepted this cycle (handshake = imem_req & imem_gnt).
REQ-012 imem_rvalid  in  1  response data valid; responses return in request order, at least 1 cycle after grant.
REQ-013 imem_rdata  in  32  response instruction word.
REQ-014 instr2  out  32  registered instruction to decode.
REQ-015 pc2  out  32  registered PC of instr2.
REQ-016 valid2  out  1  instr2/pc2 hold a real instruction; 0 = bubble.

Function
REQ-017 Fetch PC register pc_f SHALL drive imem_addr; pc_f SHALL advance by 4 (modulo 2^32, wrap from 32'hFFFF_FFFC to 0) on each accepted request.
REQ-018 Outstanding counter (0..2) SHALL increment on accepted request, decrement on imem_rvalid, both in one cycle leaving it unchanged.
REQ-019 Two-entry FIFO SHALL hold {pc, instr} of returned responses; entry pc SHALL come from a 2-deep in-order queue of issued addresses.
REQ-020 imem_req SHALL be asserted iff nrst high, redirect low, and outstanding + fifo_count < 2 (credit rule; guarantees no FIFO overflow).
REQ-021 Output update when stall low and redirect low: if FIFO non-empty, pop head into instr2/pc2, valid2=1; else if imem_rvalid (non-discarded), bypass response directly into instr2/pc2, valid2=1; else instr2=NOP_INSTR, valid2=0, pc2 unchanged.
REQ-022 Response arriving while stall high or FIFO non-empty SHALL be written to FIFO tail; simultaneous push and pop SHALL keep ordering.
REQ-023 stall high (redirect low): instr2, pc2, valid2 SHALL hold; fetching SHALL continue until credits exhausted.
REQ-024 redirect high SHALL override stall: pc_f <= {target_pc[31:2],2'b00}; FIFO emptied; instr2=NOP_INSTR, valid2=0; imem_req low that cycle.
REQ-025 On redirect, all outstanding requests (including any responding in the same cycle) SHALL be marked discard; discarded responses SHALL be dropped on arrival and never reach FIFO or output.
REQ-026 First request to the new target SHALL be issued the cycle after redirect, subject to REQ-020.
REQ-027 Latency: with grant in cycle N and rvalid in N+1, valid2 SHALL rise after the clock edge ending cycle N+1; steady-state throughput SHALL be one instruction per cycle with zero-wait memory.
REQ-028 imem_rvalid with outstanding = 0 SHALL be ignored (no state change).
REQ-029 Back-to-back redirects SHALL each restart fetch; only the last target's instructions SHALL appear.

Reset
REQ-030 While nrst low: pc_f=RESET_PC, outstanding=0, discard count=0, FIFO empty, instr2=NOP_INSTR, pc2=0, valid2=0, imem_req=0.
REQ-031 Reset asserted mid-transaction SHALL abandon all in-flight requests; responses arriving after release for pre-reset requests are not expected and SHALL be ignored per REQ-028.

Verification
REQ-032 Reset release, zero-wait memory returning addr as data -> requests 0,4,8,...; valid2 from second edge; pc2/instr2 = 0,4,8,... one per cycle.
REQ-033 stall high 3 cycles mid-stream at pc2=8 -> pc2 holds 8; imem_req drops after 2 buffered; release yields 12,16,20 with no loss/duplication.
REQ-034 redirect to 32'h0000_0103 with 2 outstanding -> next imem_addr 0x100; two old responses dropped; next valid pc2=0x100; valid2=0 meanwhile.
REQ-035 redirect and stall both high -> valid2=0, instr2=NOP_INSTR next cycle; old FIFO contents never appear.
REQ-036 RESET_PC=32'hFFFF_FFF8 -> fetch FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
REQ-037 nrst pulsed low asynchronously between edges with 2 outstanding -> outputs reset immediately; refetch from RESET_PC after release; late rvalid ignored.
